// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg: shared types and sizing helpers for the data-memory responder.
// Revision: 1.0
// ============================================================================
package dmem_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // The wait counter holds WAIT_STATES down to 1 and is never narrower than one bit
    function automatic int cnt_width(input int ws);
        return (ws < 2) ? 1 : $clog2(ws + 1);
    endfunction

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// dmem_array: DEPTH_WORDS x 32 storage, one synchronous write and read port.
// Revision: 1.0
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              rclr_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Storage carries no reset; contents are undefined until written
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    // The read register doubles as the responder's output data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rclr_i ? '0 : mem_q[ridx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder: MEM-stage load/store target with programmable wait states.
// Optional macro DMEM_ALIGN_CHECK_EN flags misaligned addresses. Revision: 1.0
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_in,
    input  logic [31:0] wr_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rd_data,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int               CNT_W    = cnt_width(WAIT_STATES);
    localparam int               IDX_W    = idx_width(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               NO_WAIT  = (WAIT_STATES == 0);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             kind_wr_q;
    logic             kind_both_q;
    logic             err_q;
    logic             ready_q;
    logic             merr_q;

    logic        req;
    logic [29:0] word_off;
    logic        out_of_range;
    logic        misaligned;
    logic        addr_err;
    logic        enter_resp;
    logic        cur_wr;
    logic        cur_both;
    logic        acc_err;
    logic        arr_we;
    logic        arr_re;

    assign req      = MemRead | MemWrite;
    // BASE_ADDR is word-aligned, so the offset is taken on word addresses directly
    assign word_off     = addr_in[31:2] - BASE_ADDR[31:2];
    assign out_of_range = ({2'b00, word_off} >= 32'(DEPTH_WORDS));

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |addr_in[1:0];
`else
    logic unused_lsbs;
    assign unused_lsbs = &{1'b0, addr_in[1:0]};
    assign misaligned  = 1'b0;
`endif

    assign addr_err = out_of_range | misaligned;

    // With no wait states the response edge is the acceptance edge, so use live inputs
    assign enter_resp = ((state_q == S_IDLE) && req && NO_WAIT)
                      || ((state_q == S_WAIT) && (cnt_q == CNT_ONE));
    assign cur_wr     = (state_q == S_IDLE) ? MemWrite : kind_wr_q;
    assign cur_both   = (state_q == S_IDLE) ? (MemRead & MemWrite) : kind_both_q;
    assign acc_err    = addr_err | cur_both;

    assign arr_we = enter_resp & cur_wr & ~addr_err;
    assign arr_re = enter_resp & (~cur_wr | acc_err);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            kind_wr_q   <= 1'b0;
            kind_both_q <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            merr_q      <= 1'b0;
        end else begin
            ready_q <= (state_q == S_RESP);
            merr_q  <= (state_q == S_RESP) & err_q;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        kind_wr_q   <= MemWrite;
                        kind_both_q <= MemRead & MemWrite;
                        if (NO_WAIT) begin
                            state_q <= S_RESP;
                            err_q   <= acc_err;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= S_RESP;
                        err_q   <= acc_err;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (arr_we),
        .widx_i  (word_off[IDX_W-1:0]),
        .wdata_i (wr_data),
        .re_i    (arr_re),
        .rclr_i  (acc_err),
        .ridx_i  (word_off[IDX_W-1:0]),
        .rdata_o (rd_data)
    );

    assign mem_ready = ready_q;
    assign mem_err   = merr_q;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder: three responder instances (2, 0, 3 wait states) checked
// against a word-level reference model. Revision: 1.0
// ============================================================================
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic [31:0] addr  [3];
    logic [31:0] wdat  [3];
    logic        mr    [3];
    logic        mw    [3];
    logic [31:0] rdat  [3];
    logic        rdy   [3];
    logic        err   [3];

    int ntests = 0;
    int nfail  = 0;

    logic [31:0] mdl [int];
    logic [31:0] exp_rd [3];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_ws2 (
        .clk(clk), .reset(rst_n[0]), .addr_in(addr[0]), .wr_data(wdat[0]),
        .MemRead(mr[0]), .MemWrite(mw[0]), .rd_data(rdat[0]),
        .mem_ready(rdy[0]), .mem_err(err[0]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
        .clk(clk), .reset(rst_n[1]), .addr_in(addr[1]), .wr_data(wdat[1]),
        .MemRead(mr[1]), .MemWrite(mw[1]), .rd_data(rdat[1]),
        .mem_ready(rdy[1]), .mem_err(err[1]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
        .clk(clk), .reset(rst_n[2]), .addr_in(addr[2]), .wr_data(wdat[2]),
        .MemRead(mr[2]), .MemWrite(mw[2]), .rd_data(rdat[2]),
        .mem_ready(rdy[2]), .mem_err(err[2]));

    function automatic int ws_of(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ntests++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One complete access: ready must appear exactly WAIT_STATES+1 edges after acceptance
    task automatic access(input int d, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] data);
        int          lat;
        int          key;
        logic [31:0] widx;
        bit          oor;
        bit          mis;
        bit          e;
        bit          known;
        lat   = ws_of(d) + 2;
        widx  = a >> 2;
        oor   = (widx >= DEPTH);
        mis   = ALIGN && (a[1:0] != 2'b00);
        e     = oor || mis || (r && w);
        key   = d * 4096 + int'(widx[11:0]);
        known = 1'b1;
        if (w && !(oor || mis)) mdl[key] = data;
        if (e) begin
            exp_rd[d] = 32'h0;
        end else if (r && !w) begin
            if (mdl.exists(key)) exp_rd[d] = mdl[key];
            else known = 1'b0;
        end

        @(negedge clk);
        addr[d] = a; wdat[d] = data; mr[d] = r; mw[d] = w;
        for (int n = 1; n <= lat; n++) begin
            @(posedge clk); #1;
            if (n < lat) chk("ready_early", {31'b0, rdy[d]}, 32'd0);
        end
        chk("ready", {31'b0, rdy[d]}, 32'd1);
        chk("mem_err", {31'b0, err[d]}, {31'b0, e});
        if (known) chk("rd_data", rdat[d], exp_rd[d]);
        mr[d] = 1'b0; mw[d] = 1'b0;
        @(posedge clk); #1;
        chk("ready_pulse", {31'b0, rdy[d]}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; addr[d] = '0; wdat[d] = '0; mr[d] = 1'b0; mw[d] = 1'b0;
            exp_rd[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_rd_data", rdat[d], 32'h0);
            chk("reset_ready", {31'b0, rdy[d]}, 32'd0);
            chk("reset_err", {31'b0, err[d]}, 32'd0);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        // Basic store/load, two wait states
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);

        // Out-of-range store leaves word 0 intact
        access(0, 1'b0, 1'b1, 32'h000, 32'h1111_2222);
        access(0, 1'b1, 1'b0, 32'h000, 32'h0);
        access(0, 1'b0, 1'b1, 32'h400, 32'h1234);
        access(0, 1'b1, 1'b0, 32'h000, 32'h0);
        access(0, 1'b1, 1'b0, 32'h404, 32'h0);

        // Simultaneous read+write acts as a flagged write
        access(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0);

        // Misaligned store: behaviour depends on the alignment-check build
        access(0, 1'b0, 1'b1, 32'h10, 32'h0BAD_F00D);
        access(0, 1'b0, 1'b1, 32'h12, 32'h5555_AAAA);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);

        // Zero wait states, then a request held across two accesses
        access(1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
        access(1, 1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        addr[1] = 32'h40; mr[1] = 1'b1;
        @(posedge clk); #1; chk("hold_k", {31'b0, rdy[1]}, 32'd0);
        @(posedge clk); #1; chk("hold_k1", {31'b0, rdy[1]}, 32'd1);
        chk("hold_rd1", rdat[1], 32'hCAFEF00D);
        @(posedge clk); #1; chk("hold_k2", {31'b0, rdy[1]}, 32'd0);
        @(posedge clk); #1; chk("hold_k3", {31'b0, rdy[1]}, 32'd1);
        chk("hold_rd2", rdat[1], 32'hCAFEF00D);
        mr[1] = 1'b0;
        @(posedge clk); #1; chk("hold_end", {31'b0, rdy[1]}, 32'd0);

        // Reset during WAIT abandons the store
        access(2, 1'b0, 1'b1, 32'h30, 32'h1);
        access(2, 1'b1, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        addr[2] = 32'h30; wdat[2] = 32'hFFFF_FFFF; mw[2] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n[2] = 1'b0;
        #1;
        chk("rst_mid_rd", rdat[2], 32'h0);
        chk("rst_mid_ready", {31'b0, rdy[2]}, 32'd0);
        chk("rst_mid_err", {31'b0, err[2]}, 32'd0);
        mw[2] = 1'b0;
        exp_rd[2] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n[2] = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("rst_idle_ready", {31'b0, rdy[2]}, 32'd0);
        end
        access(2, 1'b1, 1'b0, 32'h30, 32'h0);

        // Randomized traffic over the low 32 words plus out-of-range addresses
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) access(d, 1'b0, 1'b1, 32'(i * 4), $urandom);
            for (int i = 0; i < 40; i++) begin
                int          kind;
                logic [31:0] a;
                kind = int'($urandom_range(0, 9));
                a    = {25'b0, $urandom_range(0, 31) * 4} | 32'($urandom_range(0, 3));
                if (kind <= 3)      access(d, 1'b0, 1'b1, a, $urandom);
                else if (kind <= 6) access(d, 1'b1, 1'b0, a, $urandom);
                else if (kind == 7) access(d, $urandom_range(0, 1) == 1, 1'b1,
                                           32'h400 + ($urandom_range(0, 4095) << 2), $urandom);
                else if (kind == 8) access(d, 1'b1, 1'b1, a, $urandom);
                else                access(d, 1'b1, 1'b0, 32'h800 + a, $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS datapath: the target end of the MEM-stage load/store interface. It accepts word read/write requests driven by the CPU (address, write data, MemRead, MemWrite), serves them from an on-chip word array after a programmable number of wait states, and returns read data with a one-cycle ready pulse. The CPU stalls on mem_ready, which lets the datapath model a realistic multi-cycle memory.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 2.
- WAIT_STATES, 2: extra cycles between request acceptance and response; 0 is allowed.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word-aligned.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr_in  in  32  byte address; held stable by the requester until mem_ready.
- wr_data  in  32  store data; held stable until mem_ready.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- rd_data  out  32  registered load data.
- mem_ready  out  1  one-cycle pulse marking completion.
- mem_err  out  1  error qualifier; valid only while mem_ready=1.

## Operation
- FSM states:
  - IDLE: if MemRead|MemWrite is high, capture the request kind, go to WAIT with the counter loaded to WAIT_STATES. If WAIT_STATES=0, go straight to RESP.
  - WAIT: decrement the counter each cycle. On the edge where the counter is 1, go to RESP.
  - RESP: mem_ready=1 for exactly this cycle, then return to IDLE.
- Address decode: word index = (addr_in - BASE_ADDR) >> 2. Index >= DEPTH_WORDS is out of range.
- Write commit: happens on the edge entering RESP, if in range and error-free.
- Read: rd_data is loaded on the same edge. On error, rd_data loads 0.
- rd_data holds its value between reads. Writes do not alter rd_data.
- mem_err=1 in RESP in either of these cases:
  - the address is out of range; the write is suppressed and rd_data is 0;
  - MemRead and MemWrite were both high at acceptance; the access is performed as a write and mem_err is still set.
- Request level is sampled only in IDLE. A request still high in the IDLE cycle after RESP is a new access.
- The array has no reset; contents are undefined until written.
- Reset outputs: rd_data=0, mem_ready=0, mem_err=0, state IDLE, counter 0.
- Reset mid-operation: an access in WAIT is abandoned with no write. An access already in RESP has already committed its write.

## Timing
- Request high at acceptance edge k in IDLE → mem_ready high in the cycle after edge k+WAIT_STATES+1.
- Worked example: WAIT_STATES=2 → acceptance edge k, response edge k+3.
- rd_data and mem_err are valid in the same cycle as mem_ready.
- Back-to-back throughput is one access per WAIT_STATES+2 cycles (RESP is followed by at least one IDLE cycle).
- No combinational path from inputs to outputs.

## Configuration
- DMEM_ALIGN_CHECK_EN:
  - Defined: addr_in[1:0] != 0 is an error. No write occurs, rd_data=0, mem_err=1.
  - Undefined: addr_in[1:0] is ignored and the access targets the enclosing word; misalignment alone never raises mem_err.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the wait-counter width constant derived from WAIT_STATES (minimum 1 bit);
  - the word-index width function $clog2(DEPTH_WORDS).
- Sub-module dmem_array: a DEPTH_WORDS x 32 array with one synchronous write port and one synchronous read port, both enabled by the FSM on the edge entering RESP. The FSM, decode and error logic stay in dmem_responder.

## Test plan
- Basic store/load, WAIT_STATES=2:
  - MemWrite, addr 0x10, data 0xDEADBEEF at edge 0 → mem_ready pulse after edge 3 with mem_err=0.
  - MemRead, addr 0x10 → rd_data=0xDEADBEEF with mem_ready, three edges after acceptance.
- Zero wait states, WAIT_STATES=0: read accepted at edge k → mem_ready after edge k+1. A request held high → next acceptance at edge k+2, ready after edge k+3.
- Out of range, DEPTH_WORDS=256: store 0x1234 to addr 0x400 → mem_err=1. A read of 0x000 before and after returns the same value.
- Simultaneous MemRead+MemWrite, addr 0x20, data 0xA5A5A5A5 → mem_err=1 on ready. A later read of 0x20 returns 0xA5A5A5A5.
- Reset during WAIT: with WAIT_STATES=3, drive reset low one edge after accepting a store of 0xFFFFFFFF to 0x30, where 0x30 previously held 0x1. Required:
  - outputs go to 0 immediately;
  - a later read of 0x30 returns 0x1.
- With DMEM_ALIGN_CHECK_EN defined, store to 0x12 → mem_err=1 and the word at 0x10 is unchanged. Without the macro, the same store writes word 0x10 with mem_err=0.
